// File: rtl/dlx_fetch_unit.sv
// DLX instruction fetch stage. Sequences the PC, runs the IRAM
// ENABLE/DATA_READY handshake with at most one request in flight, and
// buffers returned words with their PCs in a small FIFO read by decode.
module dlx_fetch_unit #(
    parameter int                      ADDRESS_SIZE = 32,
    parameter int                      WORD_SIZE    = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = '0,
    parameter int                      PC_INCREMENT = 4,
    parameter int                      FIFO_DEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [ADDRESS_SIZE-1:0] IRAM_ADDRESS,
    output logic                    IRAM_ENABLE,
    input  logic                    IRAM_DATA_READY,
    input  logic [WORD_SIZE-1:0]    IRAM_DATA,
    input  logic                    redirect_valid,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic                    if_valid,
    output logic [WORD_SIZE-1:0]    if_instr,
    output logic [ADDRESS_SIZE-1:0] if_pc,
    input  logic                    if_ready
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0]        LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]        DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDRESS_SIZE-1:0] PC_STEP  = ADDRESS_SIZE'(PC_INCREMENT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]              state_q;
    logic [ADDRESS_SIZE-1:0] pc_q;
    logic [ADDRESS_SIZE-1:0] addr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [PTR_W-1:0]        head_q;
    logic [PTR_W-1:0]        tail_q;

    logic [ADDRESS_SIZE-1:0] buf_pc    [FIFO_DEPTH];
    logic [WORD_SIZE-1:0]    buf_instr [FIFO_DEPTH];

    logic                    credit;
    logic                    push;
    logic                    pop;
    logic [ADDRESS_SIZE-1:0] redir_target;
    logic                    unused_redirect_lo;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Requests are only issued from IDLE, so nothing is in flight when the
    // credit is evaluated and the buffer occupancy alone decides it.
    assign credit = (cnt_q < DEPTH_C);

    // A redirect discards any same-cycle response; a pop is still honoured.
    assign push = (state_q == S_REQ) && IRAM_DATA_READY && !redirect_valid;
    assign pop  = if_valid && if_ready;

    // Branch targets are forced to word alignment.
    assign redir_target       = {redirect_pc[ADDRESS_SIZE-1:2], 2'b00};
    assign unused_redirect_lo = ^redirect_pc[1:0];

    assign IRAM_ENABLE  = (state_q != S_IDLE);
    assign IRAM_ADDRESS = addr_q;
    assign if_valid     = (cnt_q != '0);
    assign if_instr     = if_valid ? buf_instr[head_q] : '0;
    assign if_pc        = if_valid ? buf_pc[head_q]    : '0;

    // Fetch FSM, PC and FIFO bookkeeping; redirect outranks push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            cnt_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (redirect_valid) begin
            pc_q   <= redir_target;
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            case (state_q)
                S_REQ, S_DROP: state_q <= IRAM_DATA_READY ? S_IDLE : S_DROP;
                default:       state_q <= S_IDLE;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (credit) begin
                        state_q <= S_REQ;
                        addr_q  <= pc_q;
                    end
                end
                S_REQ: begin
                    if (IRAM_DATA_READY) begin
                        state_q <= S_IDLE;
                        pc_q    <= pc_q + PC_STEP;
                    end
                end
                S_DROP: begin
                    if (IRAM_DATA_READY) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (push) begin
                tail_q <= ptr_next(tail_q);
            end
            if (pop) begin
                head_q <= ptr_next(head_q);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Buffer storage; contents are qualified by the count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc[tail_q]    <= addr_q;
            buf_instr[tail_q] <= IRAM_DATA;
        end
    end

endmodule
